// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x8 register file feeding a registered, ready/valid ALU operand slot.
// Define OPERAND_FETCH_BYPASS_EN to forward writeback data at accept and into a stalled held operand.
module operand_fetch #(
   parameter bit ZERO_REG = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_ctrl,
   input  logic [2:0] in_rs1_addr,
   input  logic [2:0] in_rs2_addr,
   input  logic [2:0] in_rd_addr,
   input  logic       wb_en,
   input  logic [2:0] wb_addr,
   input  logic [7:0] wb_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] rs1,
   output logic [7:0] rs2,
   output logic [2:0] ctrl,
   output logic [2:0] rd_addr
);

   logic [7:0] rf [8];
   logic       accept;
   logic       wr_ok;
   logic [7:0] rd1;
   logic [7:0] rd2;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // a write to r0 is dropped entirely, so it must never be forwarded either
   assign wr_ok    = wb_en && !(ZERO_REG && (wb_addr == 3'd0));

   always_comb begin
      rd1 = (ZERO_REG && (in_rs1_addr == 3'd0)) ? 8'h00 : rf[in_rs1_addr];
      rd2 = (ZERO_REG && (in_rs2_addr == 3'd0)) ? 8'h00 : rf[in_rs2_addr];
`ifdef OPERAND_FETCH_BYPASS_EN
      if (wr_ok && (wb_addr == in_rs1_addr)) rd1 = wb_data;
      if (wr_ok && (wb_addr == in_rs2_addr)) rd2 = wb_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      end else if (wr_ok) begin
         rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OPERAND_FETCH_BYPASS_EN
   logic [2:0] src1_q;
   logic [2:0] src2_q;
   logic       stall;

   assign stall = out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1     <= 8'h00;
         rs2     <= 8'h00;
         ctrl    <= 3'b000;
         rd_addr <= 3'b000;
         src1_q  <= 3'd0;
         src2_q  <= 3'd0;
      end else if (accept) begin
         rs1     <= rd1;
         rs2     <= rd2;
         ctrl    <= in_ctrl;
         rd_addr <= in_rd_addr;
         src1_q  <= in_rs1_addr;
         src2_q  <= in_rs2_addr;
      end else if (stall && wr_ok) begin
         // held operands snoop writeback so the ALU never consumes a stale value
         if (wb_addr == src1_q) rs1 <= wb_data;
         if (wb_addr == src2_q) rs2 <= wb_data;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1     <= 8'h00;
         rs2     <= 8'h00;
         ctrl    <= 3'b000;
         rd_addr <= 3'b000;
      end else if (accept) begin
         rs1     <= rd1;
         rs2     <= rd2;
         ctrl    <= in_ctrl;
         rd_addr <= in_rd_addr;
      end
   end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic against a
// transaction-level model (register array + queue of pending operand sets).
module tb_operand_fetch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_ctrl = '0;
   logic [2:0] in_rs1_addr = '0;
   logic [2:0] in_rs2_addr = '0;
   logic [2:0] in_rd_addr = '0;
   logic       wb_en = 1'b0;
   logic [2:0] wb_addr = '0;
   logic [7:0] wb_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] rs1;
   logic [7:0] rs2;
   logic [2:0] ctrl;
   logic [2:0] rd_addr;

   int tests_run = 0;
   int tests_failed = 0;

   operand_fetch #(.ZERO_REG(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rd_addr(in_rd_addr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .rs1(rs1), .rs2(rs2), .ctrl(ctrl), .rd_addr(rd_addr)
   );

   always #5 clk = ~clk;

`ifdef OPERAND_FETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct {
      logic [7:0] v1;
      logic [7:0] v2;
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] a1;
      logic [2:0] a2;
   } op_t;

   logic [7:0] m_rf [8];
   op_t        m_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [2:0] a);
      logic [7:0] v;
      v = (a == 3'd0) ? 8'h00 : m_rf[a];
      if (BYPASS && wb_en && wb_addr != 3'd0 && wb_addr == a) v = wb_data;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_q.delete();
   endtask

   // Inputs are already driven; check in_ready, advance model across the edge, check outputs.
   task automatic tick(input string tag);
      bit had;
      bit acc;
      op_t t;
      #1;
      check({tag, ".in_ready"}, in_ready, (m_q.size() == 0) || out_ready);
      had = m_q.size() != 0;
      acc = in_valid && (!had || out_ready);
      if (BYPASS && had && !out_ready && wb_en && wb_addr != 3'd0) begin
         if (m_q[0].a1 == wb_addr) m_q[0].v1 = wb_data;
         if (m_q[0].a2 == wb_addr) m_q[0].v2 = wb_data;
      end
      if (had && out_ready) void'(m_q.pop_front());
      if (acc) begin
         t.v1 = m_read(in_rs1_addr);
         t.v2 = m_read(in_rs2_addr);
         t.op = in_ctrl;
         t.rd = in_rd_addr;
         t.a1 = in_rs1_addr;
         t.a2 = in_rs2_addr;
         m_q.push_back(t);
      end
      if (wb_en && wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".out_valid"}, out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         check({tag, ".rs1"}, rs1, m_q[0].v1);
         check({tag, ".rs2"}, rs2, m_q[0].v2);
         check({tag, ".ctrl"}, ctrl, m_q[0].op);
         check({tag, ".rd_addr"}, rd_addr, m_q[0].rd);
      end
   endtask

   task automatic drive(input bit v, input logic [2:0] op, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] rd, input bit we,
                        input logic [2:0] wa, input logic [7:0] wd, input bit ordy);
      in_valid = v; in_ctrl = op; in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd;
      wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
   endtask

   initial begin
      model_reset();
      idle();
      #12;
      check("reset.out_valid", out_valid, 0);
      check("reset.rs1", rs1, 0);
      check("reset.rs2", rs2, 0);
      check("reset.ctrl", ctrl, 0);
      check("reset.rd_addr", rd_addr, 0);
      check("reset.in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // r3 = 5A, then read r3/r0
      drive(0, 0, 0, 0, 0, 1, 3, 8'h5A, 1); tick("wr_r3");
      drive(1, 3'd0, 3, 0, 3'd1, 0, 0, 8'h00, 1); tick("acc_r3");
      check("basic.rs1", rs1, 8'h5A);
      check("basic.rs2", rs2, 8'h00);
      check("basic.valid", out_valid, 1);

      // write r2 on the accept edge
      drive(0, 0, 0, 0, 0, 1, 2, 8'h10, 1); tick("wr_r2");
      drive(1, 3'd4, 2, 3, 3'd2, 1, 2, 8'hC3, 1); tick("fwd");
      check("fwd.rs1", rs1, BYPASS ? 8'hC3 : 8'h10);

      // stall for 3 cycles, r5 written while held
      drive(1, 3'd5, 1, 5, 3'd6, 0, 0, 8'h00, 1); tick("stall_acc");
      drive(1, 3'd7, 3, 3, 3'd7, 0, 0, 8'h00, 0); tick("stall1");
      check("stall.in_ready", in_ready, 0);
      drive(1, 3'd7, 3, 3, 3'd7, 1, 5, 8'h11, 0); tick("stall2");
      drive(1, 3'd7, 3, 3, 3'd7, 0, 0, 8'h00, 0); tick("stall3");
      check("stall.ctrl", ctrl, 3'd5);
      check("snoop.rs2", rs2, BYPASS ? 8'h11 : 8'h00);
      idle(); tick("drain");

      // four back-to-back accepts
      for (int i = 0; i < 4; i++) begin
         drive(1, 3'(i), 3'(i), 3'(i + 1), 3'(i), 0, 0, 8'h00, 1);
         tick("b2b");
         check("b2b.valid", out_valid, 1);
         check("b2b.ctrl", ctrl, 3'(i));
      end
      idle(); tick("b2b_drain");
      check("b2b.drained", out_valid, 0);

      // r0 ignores writes
      drive(0, 0, 0, 0, 0, 1, 0, 8'hFF, 1); tick("wr_r0");
      drive(1, 3'd1, 0, 0, 3'd0, 0, 0, 8'h00, 1); tick("rd_r0");
      check("zero.rs1", rs1, 8'h00);

      // reset mid-stall
      drive(0, 0, 0, 0, 0, 1, 3, 8'h77, 1); tick("wr_r3b");
      drive(1, 3'd2, 3, 3, 3'd3, 0, 0, 8'h00, 0); tick("rst_acc");
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0); tick("rst_stall");
      check("rst.pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst.out_valid", out_valid, 0);
      check("rst.rs1", rs1, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check("rst.in_ready", in_ready, 1);
      drive(1, 3'd6, 3, 3, 3'd4, 0, 0, 8'h00, 1); tick("post_rst");
      check("rst.r3", rs1, 8'h00);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         drive(($urandom % 4) != 0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
               ($urandom % 2) != 0, 3'($urandom), 8'($urandom), ($urandom % 3) != 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter ZERO_REG, default 1, meaning register 0 reads as 8'h00 and ignores writes when 1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, decoded instruction present.
REQ-005 SHALL have port in_ready, output, 1, stage can accept an instruction this cycle.
REQ-006 SHALL have port in_ctrl, input, 3, ALU operation code.
REQ-007 SHALL have ports in_rs1_addr and in_rs2_addr, input, 3 each, source register indices.
REQ-008 SHALL have port in_rd_addr, input, 3, destination register index, passed through.
REQ-009 SHALL have ports wb_en (1), wb_addr (3) and wb_data (8), input, register write from writeback.
REQ-010 SHALL have port out_valid, output, 1, operands valid toward the ALU.
REQ-011 SHALL have port out_ready, input, 1, ALU side consumes operands.
REQ-012 SHALL have ports rs1 (8), rs2 (8), ctrl (3) and rd_addr (3), output, registered ALU operands, opcode and destination.

Function
REQ-013 SHALL hold an 8 x 8-bit register file with one write port and two read ports.
REQ-014 SHALL write wb_data to entry wb_addr at the clock edge when wb_en=1; with ZERO_REG=1, a write to entry 0 is dropped.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-016 SHALL accept an instruction on the edge where in_valid && in_ready, and at that edge capture the file reads of in_rs1_addr and in_rs2_addr, together with in_ctrl and in_rd_addr, into the output register.
REQ-017 SHALL set out_valid=1 on the edge after an accept, giving 1-cycle latency.
REQ-018 SHALL clear out_valid on an edge where out_valid && out_ready && !(in_valid && in_ready).
REQ-019 SHALL support back-to-back accept with out_ready held at 1: one instruction per cycle, no bubbles.
REQ-020 SHALL keep rs1, rs2, ctrl and rd_addr stable while out_valid && !out_ready, except as allowed by REQ-026.
REQ-021 SHALL read entry 0 as 8'h00 when ZERO_REG=1, including via bypass.
REQ-022 SHALL treat the operands as unsigned 8-bit values; no width conversion takes place.
REQ-023 SHALL, when in_valid is low or the stage is stalled, leave the output register unchanged apart from the REQ-018 clear.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force the following: all file entries 8'h00, out_valid=0, rs1=rs2=8'h00, ctrl=3'b000, rd_addr=3'b000.
REQ-025 SHALL discard an in-flight held operand when reset asserts mid-stall; after release, in_ready=1 and the first accept behaves as after power-up.

Configuration
REQ-026 SHALL implement macro OPERAND_FETCH_BYPASS_EN.
- Defined, accept-cycle forwarding: when wb_en=1 and wb_addr equals a source address on the accept edge, the captured operand is wb_data.
- Defined, stall snooping: while out_valid && !out_ready, a write with wb_addr equal to the held source address replaces the held operand with wb_data.
- Both bypass paths obey ZERO_REG.
- Undefined: the captured operand is the pre-write file content, and held operands are never updated.

Verification
REQ-027 SHALL pass the following: reset, write r3=8'h5A, then accept rs1=3, rs2=0 -> next cycle out_valid=1, rs1=8'h5A, rs2=8'h00.
REQ-028 SHALL pass the following: with the macro defined, write r2=8'hC3 on the same edge as an accept with rs1=2 -> rs1=8'hC3; with the macro undefined -> rs1 equals the old r2 value.
REQ-029 SHALL pass the following: out_ready=0 for 3 cycles after an accept -> in_ready=0 and outputs stable; with the macro defined, a write r5=8'h11 during the stall updates a held rs2 (address 5) to 8'h11.
REQ-030 SHALL pass the following: 4 consecutive accepts with out_ready=1 -> 4 consecutive out_valid cycles with ctrl sequence 000, 001, 010, 011.
REQ-031 SHALL pass the following: ZERO_REG=1, write r0=8'hFF then read r0 -> 8'h00.
REQ-032 SHALL pass the following: assert rst_n=0 mid-stall -> out_valid drops immediately and r3 reads 8'h00 after release.
